axi4_wr_slave_mem: RTL and testbench

AXI4 write-channel slave memory that terminates the AW, W and B channels of the AXI4 signal interface. It sits directly downstream of the interface bundle and consumes the master's write-address and write-data traffic. It stores accepted beats into an internal word-addressed memory under WSTRB control and returns one write response per burst. It is the write-side endpoint for block-level benches and a simple memory model for the system.

---
 rtl/axi4_wr_slave_mem.sv | 175 +++++++++++++++++
 tb/tb_axi4_wr_slave_mem.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_slave_mem.sv
// AXI4 write-channel slave backed by a word-addressed memory with byte-lane strobes.
// One burst is in flight at a time; a registered backdoor port reads the memory.
module axi4_wr_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned WDATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH    = 30,
  parameter int unsigned USER_WIDTH  = 4,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic [ID_WIDTH-1:0]          AWID,
  input  logic [2:0]                   AWPROT,
  input  logic [3:0]                   AWREGION,
  input  logic                         AWLOCK,
  input  logic [3:0]                   AWCACHE,
  input  logic [3:0]                   AWQOS,
  input  logic [USER_WIDTH-1:0]        AWUSER,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [WDATA_WIDTH-1:0]       WDATA,
  input  logic [WDATA_WIDTH/8-1:0]     WSTRB,
  input  logic                         WLAST,
  input  logic [USER_WIDTH-1:0]        WUSER,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [1:0]                   BRESP,
  output logic [ID_WIDTH-1:0]          BID,
  output logic [USER_WIDTH-1:0]        BUSER,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [WDATA_WIDTH-1:0]       dbg_rdata
);

  localparam int unsigned WBYTES = WDATA_WIDTH / 8;
  localparam int unsigned OFF    = $clog2(WBYTES);
  localparam int unsigned DW     = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e state_q, state_d;

  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [WDATA_WIDTH-1:0] dbg_rdata_q;
  logic [WDATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic          aw_hs, w_hs, len_hit, last_beat, oob, wr_en;
  logic [DW-1:0] widx;
  logic          unused_inputs;

  assign unused_inputs = ^{AWPROT, AWREGION, AWLOCK, AWCACHE, AWQOS, AWUSER, WUSER};

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign len_hit   = (cnt_q == {1'b0, len_q});
  assign last_beat = WLAST || len_hit;
  assign widx      = ptr_q[OFF +: DW];
  // Any address bit above the memory range makes the beat out of bounds.
  assign oob       = |ptr_q[ADDR_WIDTH-1:OFF+DW];
  assign wr_en     = w_hs && !err_q && !oob;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (aw_hs) state_d = StData;
      StData:  if (w_hs && last_beat) state_d = StResp;
      StResp:  if (BREADY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready/valid depend only on state; reset holds them low.
  always_comb begin
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    BRESP   = 2'b00;
    if (!ARESET) begin
      unique case (state_q)
        StIdle:  AWREADY = 1'b1;
        StData:  WREADY  = 1'b1;
        StResp:  begin
          BVALID = 1'b1;
          BRESP  = {err_q, 1'b0};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bid_d   = bid_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (aw_hs) begin
      bid_d   = AWID;
      len_d   = AWLEN;
      size_d  = AWSIZE;
      burst_d = AWBURST;
      ptr_d   = AWADDR;
      cnt_d   = '0;
      err_d   = AWBURST[1] || (AWSIZE > 3'(OFF));
    end else if (w_hs) begin
      cnt_d = cnt_q + 9'd1;
      if (burst_q == 2'b01) ptr_d = ptr_q + (ADDR_WIDTH'(1) << size_q);
      // WLAST and the beat count disagree only on a malformed final beat.
      err_d = err_q || oob || (WLAST != len_hit);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bid_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      bid_q   <= bid_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int i = 0; i < WBYTES; i++) begin
        if (WSTRB[i]) mem_q[widx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      dbg_rdata_q <= '0;
    end else begin
      dbg_rdata_q <= mem_q[dbg_addr];
    end
  end

  assign BID       = bid_q;
  assign BUSER     = '0;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// Bench for axi4_wr_slave_mem: directed vector table, hand sequences for reset and idle W,
// then random bursts checked against a burst-level memory model.
module tb_axi4_wr_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY;
  logic [63:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [29:0] AWID;
  logic        WVALID, WREADY, WLAST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [29:0] BID;
  logic [3:0]  BUSER;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  always #5 ACLK = ~ACLK;

  axi4_wr_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWID(AWID), .AWPROT(3'd0), .AWREGION(4'd0), .AWLOCK(1'b0),
    .AWCACHE(4'd0), .AWQOS(4'd0), .AWUSER(4'd0),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WUSER(4'd0), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID), .BUSER(BUSER),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [256];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];

  typedef struct {
    string       name;
    logic [63:0] addr;
    int          len;
    int          size;
    int          burst;
    logic [29:0] id;
    int          wlast_at;
    logic [31:0] data_base;
    int          strb_beat;
    logic [3:0]  strb_val;
    int          bready_delay;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_timeout(input string name);
    errors++;
    $display("FAIL %s: timed out", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench stopped");
  endtask

  // Burst-level reference: walks beats by address arithmetic and applies strobes.
  function automatic void model_burst(input logic [63:0] addr, input int len, input int size,
                                      input int burst, input int wlast_at,
                                      output int nb, output logic [1:0] resp);
    logic        err;
    logic [63:0] a, idx;
    int          e;
    err = (burst >= 2) || ((1 << size) > 4);
    nb  = (wlast_at >= 0 && wlast_at <= len) ? wlast_at + 1 : len + 1;
    for (int k = 0; k < nb; k++) begin
      a   = (burst == 1) ? addr + (64'(k) << size) : addr;
      idx = a >> 2;
      if (!err) begin
        if (idx >= 64'd256) err = 1'b1;
        else for (int b = 0; b < 4; b++)
          if (beat_strb[k][b]) mdl[idx[7:0]][8*b +: 8] = beat_data[k][8*b +: 8];
      end
    end
    e = nb - 1;
    if ((wlast_at == e) != (e == len)) err = 1'b1;
    resp = err ? 2'b10 : 2'b00;
  endfunction

  task automatic check_word(input string name, input logic [7:0] idx);
    dbg_addr = idx;
    @(posedge ACLK);
    @(negedge ACLK);
    chk(name, 64'(dbg_rdata), 64'(mdl[idx]));
  endtask

  task automatic wait_aw(input string name);
    int n = 0;
    AWVALID = 1'b1;
    @(negedge ACLK);
    while (!AWREADY) begin
      if (++n > 50) abort_timeout({name, "_awready"});
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic run_burst(input string name, input logic [63:0] addr, input int len,
                           input int size, input int burst, input logic [29:0] id,
                           input int wlast_at, input int bready_delay, input int gap_max,
                           output logic [1:0] got_resp);
    int          nb, n;
    logic [1:0]  exp_resp;
    logic [63:0] a;
    model_burst(addr, len, size, burst, wlast_at, nb, exp_resp);
    @(posedge ACLK); #1;
    AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWID = id;
    wait_aw(name);
    for (int k = 0; k < nb; k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          WVALID = 1'b0;
          @(posedge ACLK); #1;
        end
      end
      WVALID = 1'b1; WDATA = beat_data[k]; WSTRB = beat_strb[k]; WLAST = (k == wlast_at);
      n = 0;
      @(negedge ACLK);
      while (!WREADY) begin
        if (++n > 50) abort_timeout({name, "_wready"});
        @(negedge ACLK);
      end
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge ACLK);
    chk({name, "_bvalid_after_last"}, 64'(BVALID), 64'd1);
    chk({name, "_wready_after_last"}, 64'(WREADY), 64'd0);
    n = 0;
    while (!BVALID) begin
      if (++n > 50) abort_timeout({name, "_bvalid"});
      @(negedge ACLK);
    end
    for (int d = 0; d < bready_delay; d++) begin
      chk({name, "_hold_bvalid"}, 64'(BVALID), 64'd1);
      chk({name, "_hold_bresp"}, 64'(BRESP), 64'(exp_resp));
      chk({name, "_hold_bid"}, 64'(BID), 64'(id));
      chk({name, "_hold_awready"}, 64'(AWREADY), 64'd0);
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    chk({name, "_bresp"}, 64'(BRESP), 64'(exp_resp));
    chk({name, "_bid"}, 64'(BID), 64'(id));
    chk({name, "_buser"}, 64'(BUSER), 64'd0);
    got_resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk({name, "_awready_after_b"}, 64'(AWREADY), 64'd1);
    chk({name, "_bvalid_after_b"}, 64'(BVALID), 64'd0);
    for (int k = 0; k < nb && k < 4; k++) begin
      a = (burst == 1) ? addr + (64'(k) << size) : addr;
      a = a >> 2;
      if (a < 64'd256) check_word({name, "_mem"}, a[7:0]);
    end
  endtask

  initial begin
    logic [1:0] resp;
    ARESET = 1'b1; AWVALID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
    AWID = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; BREADY = 1'b0;
    dbg_addr = '0;

    vecs[0] = '{"single",   64'h10,  0, 2, 1, 30'd5,  0, 32'hDEADBEEF, -1, 4'hF, 0, 2'b00};
    vecs[1] = '{"incr",     64'h0,   3, 2, 1, 30'd7,  3, 32'd1,         2, 4'h3, 0, 2'b00};
    vecs[2] = '{"fixed",    64'h20,  2, 2, 0, 30'd9,  2, 32'hA,        -1, 4'hF, 0, 2'b00};
    vecs[3] = '{"oob",      64'h400, 0, 2, 1, 30'd11, 0, 32'h55,       -1, 4'hF, 0, 2'b10};
    vecs[4] = '{"wrap",     64'h30,  3, 2, 2, 30'd12, 3, 32'h77,       -1, 4'hF, 0, 2'b10};
    vecs[5] = '{"size3",    64'h50,  0, 3, 1, 30'd13, 0, 32'h99,       -1, 4'hF, 0, 2'b10};
    vecs[6] = '{"early_wl", 64'h60,  3, 2, 1, 30'd14, 1, 32'h600,      -1, 4'hF, 0, 2'b10};
    vecs[7] = '{"no_wl",    64'h70,  1, 2, 1, 30'd15, -1, 32'h700,     -1, 4'hF, 0, 2'b10};
    vecs[8] = '{"bp",       64'h80,  1, 2, 1, 30'h2ABCDEF, 1, 32'h800, -1, 4'hF, 5, 2'b00};

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_bid", 64'(BID), 64'd0);
    chk("rst_buser", 64'(BUSER), 64'd0);
    chk("rst_dbg", 64'(dbg_rdata), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_awready", 64'(AWREADY), 64'd1);

    // W presented in IDLE must not be accepted
    WVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'hF; WLAST = 1'b1;
    @(negedge ACLK);
    chk("idle_wready", 64'(WREADY), 64'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge ACLK);
    chk("idle_w_ignored_awready", 64'(AWREADY), 64'd1);

    // 256-beat fill puts the whole memory in a known state
    for (int k = 0; k < 256; k++) begin
      beat_data[k] = $urandom; beat_strb[k] = 4'hF;
    end
    run_burst("fill256", 64'h0, 255, 2, 1, 30'd1, 255, 0, 0, resp);
    chk("fill256_resp", 64'(resp), 64'd0);
    check_word("fill_last", 8'd255);

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k <= vecs[v].len; k++) begin
        beat_data[k] = vecs[v].data_base + 32'(k);
        beat_strb[k] = (k == vecs[v].strb_beat) ? vecs[v].strb_val : 4'hF;
      end
      run_burst(vecs[v].name, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                vecs[v].id, vecs[v].wlast_at, vecs[v].bready_delay, 0, resp);
      chk({vecs[v].name, "_table_resp"}, 64'(resp), 64'(vecs[v].exp_resp));
    end

    dbg_addr = 8'd4;
    @(posedge ACLK); @(negedge ACLK);
    chk("single_mem4", 64'(dbg_rdata), 64'h0000_0000_DEAD_BEEF);
    dbg_addr = 8'd8;
    @(posedge ACLK); @(negedge ACLK);
    chk("fixed_mem8", 64'(dbg_rdata), 64'hC);
    dbg_addr = 8'd2;
    @(posedge ACLK); @(negedge ACLK);
    chk("incr_mem2_low", 64'(dbg_rdata[15:0]), 64'h3);
    dbg_addr = 8'd3;
    @(posedge ACLK); @(negedge ACLK);
    chk("incr_mem3", 64'(dbg_rdata), 64'h4);

    // Reset during beat 2 of a 4-beat burst at word 16
    @(posedge ACLK); #1;
    AWADDR = 64'h40; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWID = 30'd21;
    wait_aw("rst_mid");
    for (int k = 0; k < 2; k++) begin
      WVALID = 1'b1; WDATA = 32'hA5A5_0000 + 32'(k); WSTRB = 4'hF; WLAST = 1'b0;
      mdl[16 + k] = 32'hA5A5_0000 + 32'(k);
      @(negedge ACLK);
      chk("rst_mid_wready", 64'(WREADY), 64'd1);
      @(posedge ACLK); #1;
    end
    WDATA = 32'hFFFF_FFFF; ARESET = 1'b1;
    @(negedge ACLK);
    chk("rst_mid_awready_in_rst", 64'(AWREADY), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_awready", 64'(AWREADY), 64'd1);
    chk("rst_mid_wready_idle", 64'(WREADY), 64'd0);
    repeat (3) begin
      chk("rst_mid_no_bvalid", 64'(BVALID), 64'd0);
      @(negedge ACLK);
    end
    check_word("rst_mid_beat0", 8'd16);
    check_word("rst_mid_beat1", 8'd17);
    check_word("rst_mid_beat2_unwritten", 8'd18);

    // Random bursts against the model
    for (int t = 0; t < 40; t++) begin
      int r, len, size, burst, wl;
      logic [63:0] addr;
      len   = int'($urandom_range(7, 0));
      r     = int'($urandom_range(9, 0));
      burst = (r < 4) ? 1 : (r < 8) ? 0 : (r == 8) ? 2 : 3;
      size  = ($urandom_range(9, 0) == 0) ? 3 : int'($urandom_range(2, 0));
      addr  = ($urandom_range(7, 0) == 0) ? 64'(32'h3F0 + $urandom_range(31, 0))
                                           : 64'($urandom_range(1023, 0));
      r     = int'($urandom_range(11, 0));
      wl    = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(len, 0)) : len;
      for (int k = 0; k <= len; k++) begin
        beat_data[k] = $urandom; beat_strb[k] = 4'($urandom);
      end
      run_burst("rand", addr, len, size, burst, 30'($urandom), wl,
                int'($urandom_range(3, 0)), 1, resp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
